// File: rtl/threshold_trigger_pkg.sv
// Shared types and default sizes for the threshold trigger block.
package threshold_trigger_pkg;

  localparam int TDATA_WIDTH_DEF  = 128;
  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int TRIG_COUNT_WIDTH = 16;
  localparam int POST_BEATS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_PRE = 2'd1,
    STREAM   = 2'd2
  } state_t;

endpackage

// File: rtl/threshold_trigger_cmp.sv
// Parallel signed compare of every sample in a beat against one threshold.
module beat_threshold_cmp
  import threshold_trigger_pkg::*;
#(
  parameter int TDATA_WIDTH  = TDATA_WIDTH_DEF,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
  input  logic [TDATA_WIDTH-1:0]  beat,
  input  logic [SAMPLE_WIDTH-1:0] threshold,
  output logic                    hit
);

  localparam int NUM_SAMPLES = TDATA_WIDTH / SAMPLE_WIDTH;

  logic [NUM_SAMPLES-1:0] sample_hit;

  generate
    for (genvar gi = 0; gi < NUM_SAMPLES; gi++) begin : g_cmp
      assign sample_hit[gi] = $signed(beat[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]) > $signed(threshold);
    end
  endgenerate

  assign hit = |sample_hit;

endmodule

// File: rtl/threshold_trigger.sv
// Captures a frame (pre-trigger beat, trigger beat, POST_BEATS beats) from an
// AXIS sample stream whenever a sample exceeds the signed threshold.
module threshold_trigger
  import threshold_trigger_pkg::*;
#(
  parameter int TDATA_WIDTH  = TDATA_WIDTH_DEF,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [TDATA_WIDTH-1:0]      tdata,
  input  logic                        tvalid,
  output logic                        module_ready,
  input  logic                        enable,
  input  logic [SAMPLE_WIDTH-1:0]     threshold,
  input  logic [POST_BEATS_WIDTH-1:0] post_beats,
  output logic [TDATA_WIDTH-1:0]      m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic [TRIG_COUNT_WIDTH-1:0] trig_count
);

  state_t                      state_reg, state_next;
  logic [TDATA_WIDTH-1:0]      prev_reg, hold_reg, m_tdata_reg;
  logic                        m_tvalid_reg, m_tlast_reg;
  logic [POST_BEATS_WIDTH-1:0] cnt_reg;
  logic [TRIG_COUNT_WIDTH-1:0] trig_count_reg;
  logic                        hit, in_accept, out_xfer, trigger;

  beat_threshold_cmp #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_cmp (
    .beat     (tdata),
    .threshold(threshold),
    .hit      (hit)
  );

  assign in_accept = tvalid & module_ready;
  assign out_xfer  = m_tvalid_reg & m_tready;
  assign trigger   = (state_reg == IDLE) & in_accept & enable & hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (trigger) state_next = SEND_PRE;
      SEND_PRE: if (out_xfer) state_next = (cnt_reg == '0) ? IDLE : STREAM;
      STREAM:   if (in_accept && cnt_reg == POST_BEATS_WIDTH'(1)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Idle holds off new beats until any pending TLAST beat has drained.
  always_comb begin
    module_ready = 1'b0;
    case (state_reg)
      IDLE:     module_ready = ~m_tvalid_reg;
      SEND_PRE: module_ready = 1'b0;
      STREAM:   module_ready = ~m_tvalid_reg | m_tready;
      default:  module_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg       <= '0;
      hold_reg       <= '0;
      m_tdata_reg    <= '0;
      m_tvalid_reg   <= 1'b0;
      m_tlast_reg    <= 1'b0;
      cnt_reg        <= '0;
      trig_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (out_xfer) begin
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
          end
          if (in_accept) prev_reg <= tdata;
          if (trigger) begin
            m_tdata_reg    <= prev_reg;
            m_tvalid_reg   <= 1'b1;
            m_tlast_reg    <= 1'b0;
            hold_reg       <= tdata;
            cnt_reg        <= post_beats;
            trig_count_reg <= trig_count_reg + TRIG_COUNT_WIDTH'(1);
          end
        end
        SEND_PRE: begin
          if (out_xfer) begin
            m_tdata_reg <= hold_reg;
            m_tlast_reg <= (cnt_reg == '0);
          end
        end
        STREAM: begin
          if (in_accept) begin
            m_tdata_reg  <= tdata;
            m_tvalid_reg <= 1'b1;
            m_tlast_reg  <= (cnt_reg == POST_BEATS_WIDTH'(1));
            cnt_reg      <= cnt_reg - POST_BEATS_WIDTH'(1);
          end else if (out_xfer) begin
            m_tvalid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_tdata    = m_tdata_reg;
  assign m_tvalid   = m_tvalid_reg;
  assign m_tlast    = m_tlast_reg;
  assign trig_count = trig_count_reg;

endmodule

// File: doc/threshold_trigger.md
THRESHOLD_TRIGGER -- requirements
Module: threshold_trigger

Interface
REQ-001 Parameter TDATA_WIDTH, default 128: input and output beat width in bits.
REQ-002 Parameter SAMPLE_WIDTH, default 16: width of one signed sample. TDATA_WIDTH/SAMPLE_WIDTH samples per beat; sample 0 is at the LSBs.
REQ-003 CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 TDATA  in  TDATA_WIDTH  input sample beat, from the upstream AXIS slave interface.
REQ-006 TVALID  in  1  input beat valid.
REQ-007 MODULE_READY  out  1  input beat ready, returned to the upstream interface.
REQ-008 ENABLE  in  1  arms trigger detection when high.
REQ-009 THRESHOLD  in  SAMPLE_WIDTH  signed trigger level.
REQ-010 POST_BEATS  in  8  number of beats sent after the trigger beat.
REQ-011 M_TDATA  out  TDATA_WIDTH  output frame beat.
REQ-012 M_TVALID  out  1  output beat valid.
REQ-013 M_TREADY  in  1  downstream ready.
REQ-014 M_TLAST  out  1  marks the final beat of a frame.
REQ-015 TRIG_COUNT  out  16  number of accepted triggers; wraps from 0xFFFF to 0.

Function
REQ-016 An input beat is accepted when TVALID and MODULE_READY are both high; an output beat is transferred when M_TVALID and M_TREADY are both high.
REQ-017 The block SHALL use a single output register (M_TDATA, M_TVALID, M_TLAST); M_TVALID and M_TDATA SHALL stay stable until transferred.
REQ-018 FSM states: IDLE, SEND_PRE, STREAM.
REQ-019 In IDLE: MODULE_READY = 1. Every accepted beat is stored in a previous-beat register PREV and otherwise discarded.
REQ-020 Trigger condition: in IDLE, an accepted beat with ENABLE = 1 and any sample greater than THRESHOLD (strict, signed compare).
REQ-021 On trigger: load the output register with PREV (M_TLAST = 0); store the trigger beat in HOLD; latch POST_BEATS into CNT; increment TRIG_COUNT; go to SEND_PRE.
REQ-022 In SEND_PRE: MODULE_READY = 0. When the PREV beat transfers, load HOLD into the output register with M_TLAST = (CNT == 0).
- If CNT == 0, go to IDLE.
- Otherwise go to STREAM.
REQ-023 In STREAM: MODULE_READY = !M_TVALID | M_TREADY. Each accepted beat is loaded into the output register and decrements CNT. The beat accepted when CNT == 1 carries M_TLAST = 1 and the FSM returns to IDLE.
REQ-024 Frame length SHALL be exactly POST_BEATS + 2 beats: pre-trigger beat, trigger beat, then POST_BEATS beats.
REQ-025 Threshold crossings during SEND_PRE or STREAM SHALL be ignored. ENABLE and THRESHOLD changes mid-frame SHALL NOT alter the current frame.
REQ-026 In IDLE, the output register SHALL be cleared (M_TVALID = 0) once its last beat is transferred. A trigger while a TLAST beat is still pending SHALL stall: MODULE_READY = !M_TVALID in IDLE.
REQ-027 Latency from trigger-beat acceptance to M_TVALID of the pre-trigger beat: 1 cycle.

Reset
REQ-028 On RESET, the block SHALL immediately and asynchronously set:
- FSM to IDLE.
- M_TVALID = 0, M_TLAST = 0, M_TDATA = 0.
- PREV = 0, HOLD = 0, CNT = 0, TRIG_COUNT = 0.
- MODULE_READY = 1.
REQ-029 A RESET mid-frame SHALL discard the partial frame with no TLAST emitted; the first post-reset trigger SHALL emit PREV = 0 if no beat has been accepted since reset.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, default TDATA_WIDTH/SAMPLE_WIDTH constants and the TRIG_COUNT width.
REQ-031 The per-beat parallel compare SHALL be a combinational sub-module, beat_threshold_cmp (inputs: beat, threshold; output: hit).

Verification
REQ-032 Bench scenario 1, basic frame: THRESHOLD = 100, POST_BEATS = 2, beats A (all 0), B (sample 3 = 101), C, D, E, M_TREADY = 1 -> output A, B, C, D with TLAST on D; TRIG_COUNT = 1.
REQ-033 Bench scenario 2, boundary: a sample equal to THRESHOLD (100) -> no trigger. A sample of -32768 with THRESHOLD = -32767 -> no trigger. A sample of 0x8001 with THRESHOLD = 0x8000 -> trigger.
REQ-034 Bench scenario 3, POST_BEATS = 0: trigger on beat B -> 2-beat frame (PREV, B), TLAST on B, FSM back to IDLE.
REQ-035 Bench scenario 4, backpressure: M_TREADY toggling randomly during a POST_BEATS = 5 frame -> 7 beats in order, none lost or duplicated, and M_TDATA stable while stalled.
REQ-036 Bench scenario 5, retrigger and disable: a crossing inside STREAM -> ignored (TRIG_COUNT unchanged); ENABLE = 0 with crossings -> no output.
REQ-037 Bench scenario 6, reset: RESET asserted during STREAM -> outputs zero in the same cycle; the next trigger yields a full frame beginning with PREV = 0.
